rrp_otf_convert: RTL and testbench
==================================

Name: rRp_otf_convert

Overview:
- Back-end converter for the radix-r signed-digit online datapath. It accepts one redundant signed-digit word, MSD-first, such as the multiplier's product vector.
- It converts the word to conventional two's complement using on-the-fly conversion (OTFC): one digit per cycle, no carry propagation.
- It sits between the online arithmetic blocks and any conventional-binary consumer, closing the loop opposite the digit-producing units.

Parameters:
- WIDTH, 15, number of signed digits per input word (15 = 2*7+1 matches the default product width).
- RADIX, 2, digit radix; must be a power of 2 and at least 2. D = $clog2(RADIX)+1 is the digit bitwidth; L = $clog2(RADIX).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  a word is presented on in_digits.
- in_ready  output  1  converter can accept a word.
- in_digits  input  D*WIDTH  signed digits, each D-bit two's complement. Digit 1 (MSD) sits at [D*WIDTH-1 -: D]; digit i sits at [D*(WIDTH-i+1)-1 -: D].
- out_valid  output  1  out_value holds a completed conversion.
- out_ready  input  1  consumer accepts out_value.
- out_value  output  L*WIDTH+1  two's complement integer q = sum over i=1..WIDTH of d_i*RADIX^(WIDTH-i).
- out_err  output  1  an illegal digit was seen in this word (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_value=0, out_err=0, Q=0, QM=all ones (-1), digit counter=0, captured word register=0.
- Legal digit range is -(RADIX-1)..RADIX-1. Bit pattern -RADIX (100..0) is illegal.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid && in_ready:
    - capture in_digits into a shift register;
    - set Q=0, QM=-1, count=0, out_err=0;
    - go to CONV.
  - CONV: in_ready=0. Each cycle:
    - take the top digit d and shift the register left by D;
    - increment count;
    - update Q and QM per the OTFC rules below.
    - After the WIDTH-th digit, load out_value from the final Q and go to DONE.
    - in_valid is ignored here.
  - DONE: out_valid=1; out_value and out_err are stable. On out_ready, go to IDLE with out_valid=0 on the next cycle.
- OTFC update, with Q and QM each L*WIDTH+1 bits:
  - Q' = (d>=0) ? {Q, d[L-1:0]} : {QM, (RADIX+d)[L-1:0]}.
  - QM' = (d>0) ? {Q, (d-1)[L-1:0]} : {QM, (RADIX-1+d)[L-1:0]}.
  - Both shift left by L; bits above the width are discarded.
  - Invariant: QM = Q - 1 after every step.
- Latency: accept on edge t; digits are consumed on edges t+1..t+WIDTH; out_valid is high from after edge t+WIDTH.
- Throughput: at most one word per WIDTH+2 cycles when out_ready is held high. There is no overlap; in_ready is low in CONV and DONE.
- Back-pressure: DONE holds indefinitely while out_ready=0, and out_value must not change.
- Reset mid-CONV or mid-DONE: the frame is aborted immediately, outputs return to reset values, and no partial result is emitted.
- in_digits may change after acceptance without affecting the result.

Optional Feature:
- Macro: RRP_OTF_ERR_CHECK_EN.
- With the macro defined:
  - each digit consumed in CONV is compared against the pattern -RADIX;
  - a match sets a sticky error flag for the frame, presented on out_err alongside out_valid;
  - conversion still completes, using the raw digit bits in the update.
  - The flag clears on the next accept or on reset.
- Without the macro: out_err is tied to 0 and no checking logic is built.

Test Plan:
1. RADIX=2, WIDTH=4, digits [1,-1,0,1] (in_digits=01_11_00_01), out_ready=1 → out_value=5'b00101 (5). out_valid rises 4 cycles after the accept edge and lasts exactly 1 cycle.
2. RADIX=2, WIDTH=4, digits [-1,-1,-1,-1] then [-1,0,0,0] back-to-back → -15 (5'b10001) then -8 (5'b11000). in_ready is low throughout CONV and DONE.
3. RADIX=4, WIDTH=3, digits [3,-3,2] (011_101_010) → out_value=7'b0100110 (38). Also all-zero digits → 0.
4. Back-pressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_value is constant, and a pulse on in_valid is ignored. Release → IDLE, in_ready=1.
5. Assert reset for 1 cycle, two cycles into CONV → out_valid=0, in_ready=1, and no result emitted. A new word then converts correctly.
6. With RRP_OTF_ERR_CHECK_EN defined, RADIX=4, WIDTH=3, digits [1,-4,0] (001_100_000) → out_err=1 with out_valid. The next legal word gives out_err=0. Without the macro, out_err stays 0.

Source files
------------

// File: rtl/rrp_otf_convert.sv
// ----------------------------------------------------------------------------
// rrp_otf_convert
// Converts one MSD-first radix-RADIX signed-digit word into a two's
// complement integer by on-the-fly conversion. One digit is consumed per
// cycle and there is no carry propagation.
//
// Parameters
//   WIDTH  number of signed digits per word
//   RADIX  digit radix (power of two, >= 2); digit width D = log2(RADIX)+1
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   word present on in_digits
//   in_ready   converter can accept a word (registered)
//   in_digits  WIDTH digits, D-bit two's complement each, MSD in the top bits
//   out_valid  out_value holds a completed conversion (registered)
//   out_ready  consumer accepts out_value
//   out_value  converted integer, log2(RADIX)*WIDTH+1 bits (registered)
//   out_err    an illegal digit (-RADIX) was seen in this word
//
// Build option
//   RRP_OTF_ERR_CHECK_EN  when defined, digits equal to -RADIX raise a
//                         sticky per-frame flag shown on out_err; otherwise
//                         out_err is tied low.
// ----------------------------------------------------------------------------
module rrp_otf_convert #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned RADIX = 2
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [($clog2(RADIX)+1)*WIDTH-1:0]     in_digits,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [$clog2(RADIX)*WIDTH:0]           out_value,
    output logic                                   out_err
);

    localparam int unsigned L  = $clog2(RADIX);
    localparam int unsigned D  = L + 1;
    localparam int unsigned N  = L * WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [D*WIDTH-1:0] r_word;
    logic [N-1:0]       r_q;
    logic [N-1:0]       r_qm;
    logic [CW-1:0]      r_count;

    logic [D-1:0]       w_d;
    logic               w_d_neg;
    logic               w_d_pos;
    logic [L-1:0]       w_dm1;
    logic [N-1:0]       w_q_next;
    logic [N-1:0]       w_qm_next;
    logic               w_accept;
    logic               w_last;

    // Current digit is always the top slot of the shift register.
    assign w_d     = r_word[D*WIDTH-1 -: D];
    assign w_d_neg = w_d[D-1];
    assign w_d_pos = !w_d_neg && (w_d != '0);

    // RADIX = 2^L, so (RADIX+d) and d share their low L bits, and likewise
    // (RADIX-1+d) and (d-1); only d and d-1 are needed for the appended digit.
    assign w_dm1     = w_d[L-1:0] - L'(1);
    assign w_q_next  = w_d_neg ? {r_qm[N-L-1:0], w_d[L-1:0]} : {r_q[N-L-1:0], w_d[L-1:0]};
    assign w_qm_next = w_d_pos ? {r_q[N-L-1:0], w_dm1}       : {r_qm[N-L-1:0], w_dm1};

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_count == CW'(WIDTH - 1));

    // State register and registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            in_ready  <= (w_state_next == S_IDLE);
            out_valid <= (w_state_next == S_DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_next = S_CONV;
            S_CONV:  if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Conversion datapath: capture, shift, Q/QM update, result load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_word    <= '0;
            r_q       <= '0;
            r_qm      <= '1;
            r_count   <= '0;
            out_value <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_word  <= in_digits;
                        r_q     <= '0;
                        r_qm    <= '1;
                        r_count <= '0;
                    end
                end
                S_CONV: begin
                    r_word  <= r_word << D;
                    r_count <= r_count + CW'(1);
                    r_q     <= w_q_next;
                    r_qm    <= w_qm_next;
                    if (w_last) out_value <= w_q_next;
                end
                default: ;
            endcase
        end
    end

`ifdef RRP_OTF_ERR_CHECK_EN
    logic r_err;
    logic w_illegal;

    // -RADIX is the single D-bit pattern outside the legal digit set.
    assign w_illegal = (w_d == {1'b1, {L{1'b0}}});

    // Sticky per-frame flag; published on out_err with the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err   <= 1'b0;
            out_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_err   <= 1'b0;
                        out_err <= 1'b0;
                    end
                end
                S_CONV: begin
                    r_err <= r_err | w_illegal;
                    if (w_last) out_err <= r_err | w_illegal;
                end
                default: ;
            endcase
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_rrp_otf_convert.sv
// ----------------------------------------------------------------------------
// tb_rrp_otf_convert
// Directed, table-driven bench for rrp_otf_convert. Two instances are used:
// RADIX=2/WIDTH=4 and RADIX=4/WIDTH=3. Expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_rrp_otf_convert;

`ifdef RRP_OTF_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       out_ready;

    logic       iv2, ir2, ov2, oe2;
    logic [7:0] id2;
    logic [4:0] oval2;

    logic       iv4, ir4, ov4, oe4;
    logic [8:0] id4;
    logic [6:0] oval4;

    logic       sel;
    logic       o_rdy, o_vld, o_err;
    logic [6:0] o_val;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    rrp_otf_convert #(.WIDTH(4), .RADIX(2)) u_r2 (
        .clock(clock), .reset(reset),
        .in_valid(iv2), .in_ready(ir2), .in_digits(id2),
        .out_valid(ov2), .out_ready(out_ready), .out_value(oval2), .out_err(oe2)
    );

    rrp_otf_convert #(.WIDTH(3), .RADIX(4)) u_r4 (
        .clock(clock), .reset(reset),
        .in_valid(iv4), .in_ready(ir4), .in_digits(id4),
        .out_valid(ov4), .out_ready(out_ready), .out_value(oval4), .out_err(oe4)
    );

    assign o_rdy = sel ? ir4 : ir2;
    assign o_vld = sel ? ov4 : ov2;
    assign o_err = sel ? oe4 : oe2;
    assign o_val = sel ? oval4 : {2'b00, oval2};

    typedef struct {
        bit         s;       // 0: radix-2 instance, 1: radix-4 instance
        logic [8:0] digits;
        logic [6:0] exp_val;
        bit         illegal;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [8:0] dig);
        if (sel) begin
            iv4 = v; id4 = dig;
        end else begin
            iv2 = v; id2 = dig[7:0];
        end
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!o_rdy && n < 20) begin
            tick();
            n++;
        end
        if (!o_rdy) check({nm, "_ready_timeout"}, 32'(o_rdy), 32'd1);
    endtask

    // Accept one word, check latency, in_ready low throughout, value, err,
    // and a one-cycle out_valid with out_ready held high.
    task automatic run_word(input bit s, input logic [8:0] dig, input logic [6:0] exp_v,
                            input bit exp_e, input string nm);
        int lat;
        bit rdy_low;
        int w;
        sel = s;
        w = s ? 3 : 4;
        wait_ready(nm);
        drive(1'b1, dig);
        tick();
        drive(1'b0, ~dig);
        lat = 0;
        rdy_low = 1'b1;
        while (!o_vld && lat < 20) begin
            if (o_rdy) rdy_low = 1'b0;
            tick();
            lat++;
        end
        if (o_rdy) rdy_low = 1'b0;
        check({nm, "_latency"}, 32'(lat), 32'(w));
        check({nm, "_value"}, 32'(o_val), 32'(exp_v));
        check({nm, "_err"}, 32'(o_err), 32'(exp_e));
        check({nm, "_busy"}, 32'(rdy_low), 32'd1);
        tick();
        check({nm, "_vld_pulse"}, 32'(o_vld), 32'd0);
        check({nm, "_rdy_back"}, 32'(o_rdy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [6:0] held;

        reset = 1'b1; out_ready = 1'b1; sel = 1'b0;
        iv2 = 1'b0; id2 = '0; iv4 = 1'b0; id4 = '0;

        // {s, digits, expected, illegal}
        vecs.push_back('{1'b0, 9'b0_01_11_00_01, 7'b00_00101, 1'b0, "r2_p1m1z1"});
        vecs.push_back('{1'b0, 9'b0_11_11_11_11, 7'b00_10001, 1'b0, "r2_allm1"});
        vecs.push_back('{1'b0, 9'b0_11_00_00_00, 7'b00_11000, 1'b0, "r2_m8"});
        vecs.push_back('{1'b0, 9'b0_01_01_01_01, 7'b00_01111, 1'b0, "r2_all1"});
        vecs.push_back('{1'b0, 9'b0_00_00_00_00, 7'b00_00000, 1'b0, "r2_zero"});
        vecs.push_back('{1'b0, 9'b0_01_00_00_11, 7'b00_00111, 1'b0, "r2_7"});
        vecs.push_back('{1'b0, 9'b0_00_11_01_00, 7'b00_11110, 1'b0, "r2_m2"});
        vecs.push_back('{1'b1, 9'b011_101_010,   7'b0100110,  1'b0, "r4_38"});
        vecs.push_back('{1'b1, 9'b000_000_000,   7'b0000000,  1'b0, "r4_zero"});
        vecs.push_back('{1'b1, 9'b101_101_101,   7'b1000001,  1'b0, "r4_m63"});
        vecs.push_back('{1'b1, 9'b011_011_011,   7'b0111111,  1'b0, "r4_63"});
        vecs.push_back('{1'b1, 9'b111_010_000,   7'b1111000,  1'b0, "r4_m8"});
        vecs.push_back('{1'b1, 9'b001_100_000,   7'b0000000,  1'b1, "r4_illegal"});
        vecs.push_back('{1'b1, 9'b011_101_010,   7'b0100110,  1'b0, "r4_after_err"});

        // Reset state.
        tick();
        check("rst_ir2", 32'(ir2), 32'd1);
        check("rst_ov2", 32'(ov2), 32'd0);
        check("rst_val2", 32'(oval2), 32'd0);
        check("rst_oe2", 32'(oe2), 32'd0);
        check("rst_ir4", 32'(ir4), 32'd1);
        check("rst_ov4", 32'(ov4), 32'd0);
        check("rst_val4", 32'(oval4), 32'd0);
        reset = 1'b0;
        tick();

        // Back-to-back table run (out_ready held high).
        foreach (vecs[i])
            run_word(vecs[i].s, vecs[i].digits, vecs[i].exp_val,
                     vecs[i].illegal & ERR_EN, vecs[i].name);

        // Back-pressure: DONE holds for 10 cycles; an in_valid pulse is ignored.
        sel = 1'b0;
        out_ready = 1'b0;
        wait_ready("bp");
        drive(1'b1, 9'b0_01_11_00_01);
        tick();
        drive(1'b0, '0);
        for (int i = 0; i < 10 && !o_vld; i++) tick();
        check("bp_valid", 32'(o_vld), 32'd1);
        held = o_val;
        check("bp_value", 32'(held), 32'd5);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(i == 3, 9'b0_01_01_01_01);
            tick();
            if (!o_vld || o_val !== held || o_rdy) ok = 1'b0;
        end
        drive(1'b0, '0);
        check("bp_hold", 32'(ok), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_release_vld", 32'(o_vld), 32'd0);
        check("bp_release_rdy", 32'(o_rdy), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_vld) ok = 1'b0;
        end
        check("bp_pulse_ignored", 32'(ok), 32'd1);

        // Reset two cycles into CONV aborts the frame.
        wait_ready("rst_mid");
        drive(1'b1, 9'b0_11_11_11_11);
        tick();
        drive(1'b0, '0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort_vld", 32'(o_vld), 32'd0);
        check("abort_rdy", 32'(o_rdy), 32'd1);
        check("abort_val", 32'(o_val), 32'd0);
        tick();
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_vld) ok = 1'b0;
        end
        check("abort_no_result", 32'(ok), 32'd1);
        run_word(1'b0, 9'b0_00_11_01_00, 7'b00_11110, 1'b0, "post_rst");
        run_word(1'b1, 9'b001_100_000, 7'b0000000, ERR_EN, "post_rst_err");
        run_word(1'b1, 9'b111_010_000, 7'b1111000, 1'b0, "post_rst_r4");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
